// File: rtl/fifo_umbral.sv
// Per-lane synchronous FIFO with registered read data, programmable almost-empty/almost-full
// thresholds latched from a shared bus during init, and sticky overflow/underflow errors.
module fifo_umbral #(
    parameter int DATA_WIDTH   = 10,
    parameter int ADDR_WIDTH   = 3,
    parameter int UMBRALES_L_H = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRALES_L_H-1:0] umbral_LH,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = UMBRALES_L_H / 2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic [TW-1:0]         umbral_h_q, umbral_h_d;
    logic [TW-1:0]         umbral_l_q, umbral_l_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic          push_ok;
    logic          pop_ok;
    logic [TW-1:0] lh_high;

    assign empty        = (count_q == '0);
    assign full         = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign almost_empty = (int'(count_q) <= int'(umbral_l_q));
    assign almost_full  = (int'(count_q) >= int'(umbral_h_q));

    // A pop frees a slot on the same edge, so a full FIFO can still take a push alongside it.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign lh_high = umbral_LH[UMBRALES_L_H-1:TW];

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        umbral_h_d  = umbral_h_q;
        umbral_l_d  = umbral_l_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && !push_ok) overflow_d = 1'b1;
        if (pop && !pop_ok)   underflow_d = 1'b1;

        // A high threshold beyond DEPTH could never be reached; clamp so almost_full tracks full.
        if (init) begin
            umbral_l_d = umbral_LH[TW-1:0];
            if (int'(lh_high) > DEPTH) umbral_h_d = TW'(DEPTH);
            else                       umbral_h_d = lh_high;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            umbral_h_q  <= TW'(DEPTH - 1);
            umbral_l_q  <= TW'(1);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            umbral_h_q  <= umbral_h_d;
            umbral_l_q  <= umbral_l_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign count         = count_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule
